// File: rtl/sram_arbiter3.sv
// sram_arbiter3: shares one 512K x 8 SRAM between video, CPU and loader.
// Fixed priority vid > cpu > ldr, with a starvation counter for the loader.
module sram_arbiter3 #(
    parameter int ACCESS_CYCLES = 3,
    parameter int LDR_MAXWAIT   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vid_req,
    input  logic [18:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_dout,
    input  logic        cpu_req,
    input  logic        cpu_we_n,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    input  logic        ldr_req,
    input  logic        ldr_we_n,
    input  logic [18:0] ldr_addr,
    input  logic [7:0]  ldr_din,
    output logic [7:0]  ldr_dout,
    output logic        ldr_ack,
    output logic [18:0] sram_addr,
    output logic [7:0]  sram_dout,
    input  logic [7:0]  sram_din,
    output logic        sram_oe,
    output logic        sram_we_n,
    output logic [1:0]  grant
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ACK    = 2'd2;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_VID  = 2'b01;
    localparam logic [1:0] G_CPU  = 2'b10;
    localparam logic [1:0] G_LDR  = 2'b11;

    localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] MAXW = 4'(LDR_MAXWAIT);

    logic [1:0] state;
    logic [3:0] phase;
    logic [3:0] wait_cnt;
    logic       wr;
    logic [1:0] win;

    // Pick the next owner; a starving loader outranks the CPU but not video
    always_comb begin
        win = G_NONE;
        priority case (1'b1)
            vid_req:                     win = G_VID;
            ldr_req && wait_cnt == MAXW: win = G_LDR;
            cpu_req:                     win = G_CPU;
            ldr_req:                     win = G_LDR;
            default:                     win = G_NONE;
        endcase
    end

    // Strobes derive from registered state so reset releases them at once
    assign sram_oe   = (state == S_ACCESS) && wr;
    assign sram_we_n = !((state == S_ACCESS) && wr &&
                         (phase != 4'd0) && (phase != LAST));

    assign vid_ack = (state == S_ACK) && (grant == G_VID);
    assign cpu_ack = (state == S_ACK) && (grant == G_CPU);
    assign ldr_ack = (state == S_ACK) && (grant == G_LDR);

    // Arbitration, access sequencing and read-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            phase     <= 4'd0;
            wait_cnt  <= 4'd0;
            wr        <= 1'b0;
            grant     <= G_NONE;
            sram_addr <= 19'd0;
            sram_dout <= 8'd0;
            vid_dout  <= 8'd0;
            cpu_dout  <= 8'd0;
            ldr_dout  <= 8'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (win != G_NONE) begin
                        grant <= win;
                        phase <= 4'd0;
                        state <= S_ACCESS;
                        unique case (win)
                            G_VID: begin
                                sram_addr <= vid_addr;
                                wr        <= 1'b0;
                                sram_dout <= 8'd0;
                            end
                            G_CPU: begin
                                sram_addr <= cpu_addr;
                                wr        <= !cpu_we_n;
                                sram_dout <= cpu_din;
                            end
                            default: begin
                                sram_addr <= ldr_addr;
                                wr        <= !ldr_we_n;
                                sram_dout <= ldr_din;
                            end
                        endcase
                        if (win == G_LDR)
                            wait_cnt <= 4'd0;
                        else if (ldr_req && wait_cnt != MAXW)
                            wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_ACCESS: begin
                    phase <= phase + 4'd1;
                    if (phase == LAST) begin
                        state <= S_ACK;
                        if (!wr) begin
                            unique case (grant)
                                G_VID:   vid_dout <= sram_din;
                                G_CPU:   cpu_dout <= sram_din;
                                G_LDR:   ldr_dout <= sram_din;
                                default: ;
                            endcase
                        end
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                    grant <= G_NONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter3.sv
// tb_sram_arbiter3: scoreboard bench for sram_arbiter3.
// Expected acks are queued by stimulus and popped by a negedge monitor.
module tb_sram_arbiter3;

    localparam int AC = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vid_req = 1'b0;
    logic [18:0] vid_addr = '0;
    logic        vid_ack;
    logic [7:0]  vid_dout;
    logic        cpu_req = 1'b0;
    logic        cpu_we_n = 1'b1;
    logic [18:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        ldr_req = 1'b0;
    logic        ldr_we_n = 1'b1;
    logic [18:0] ldr_addr = '0;
    logic [7:0]  ldr_din = '0;
    logic [7:0]  ldr_dout;
    logic        ldr_ack;
    logic [18:0] sram_addr;
    logic [7:0]  sram_dout;
    logic [7:0]  sram_din = '0;
    logic        sram_oe;
    logic        sram_we_n;
    logic [1:0]  grant;

    sram_arbiter3 #(.ACCESS_CYCLES(3), .LDR_MAXWAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_ack(vid_ack), .vid_dout(vid_dout),
        .cpu_req(cpu_req), .cpu_we_n(cpu_we_n),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we_n(ldr_we_n),
        .ldr_addr(ldr_addr), .ldr_din(ldr_din),
        .ldr_dout(ldr_dout), .ldr_ack(ldr_ack),
        .sram_addr(sram_addr), .sram_dout(sram_dout),
        .sram_din(sram_din), .sram_oe(sram_oe),
        .sram_we_n(sram_we_n), .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] dout;
    } exp_t;

    exp_t sbq[$];
    int   ack_cyc[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.dout = d;
        sbq.push_back(e);
    endtask

    // Monitor: every ack pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && (vid_ack || cpu_ack || ldr_ack)) begin
            automatic int mk;
            automatic logic [7:0] md;
            automatic exp_t e;
            chk("ack_onehot",
                int'(vid_ack) + int'(cpu_ack) + int'(ldr_ack), 1);
            mk = vid_ack ? 1 : (cpu_ack ? 2 : 3);
            md = vid_ack ? vid_dout : (cpu_ack ? cpu_dout : ldr_dout);
            if (sbq.size() == 0) begin
                chk("unexpected_ack", mk, 0);
            end else begin
                e = sbq.pop_front();
                chk("ack_kind", mk, e.kind);
                chk("ack_grant", grant, e.kind);
                chk("ack_dout", md, e.dout);
                ack_cyc.push_back(cyc);
            end
        end
    end

    // Single CPU access with cycle-exact strobe checks
    task automatic cpu_access(input logic we_n, input logic [18:0] a,
                              input logic [7:0] d, input logic [7:0] rd,
                              input logic [7:0] exp_dout);
        @(posedge clk); #1;
        cpu_req = 1'b1;
        cpu_we_n = we_n;
        cpu_addr = a;
        cpu_din = d;
        sram_din = rd;
        push(2, exp_dout);
        @(posedge clk); #1;
        cpu_addr = 19'h0;
        cpu_din = 8'h0;
        for (int i = 0; i < AC; i++) begin
            @(negedge clk);
            chk("acc_addr", sram_addr, a);
            chk("acc_oe", sram_oe, !we_n);
            chk("acc_we_n", sram_we_n,
                (!we_n && i >= 1 && i <= AC - 2) ? 1'b0 : 1'b1);
            chk("acc_noack", cpu_ack, 1'b0);
            if (!we_n) chk("acc_sram_dout", sram_dout, d);
        end
        @(negedge clk);
        chk("ack_pulse", cpu_ack, 1'b1);
        chk("ack_oe", sram_oe, 1'b0);
        chk("ack_we_n", sram_we_n, 1'b1);
        chk("ack_cpu_dout", cpu_dout, exp_dout);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("ack_single", cpu_ack, 1'b0);
        chk("idle_grant", grant, 2'b00);
    endtask

    // Service acks as they come, dropping reqs on the edge that ends ACK
    task automatic run_acks(input int nacks, input int maxcyc,
                            input logic [7:0] d0,
                            input logic hold_cpu, input logic hold_ldr);
        int seen = 0;
        int c = 0;
        logic dv, dc, dl;
        sram_din = d0;
        while (seen < nacks && c < maxcyc) begin
            @(negedge clk);
            c++;
            dv = vid_ack;
            dc = cpu_ack;
            dl = ldr_ack;
            @(posedge clk); #1;
            if (dv || dc || dl) begin
                seen++;
                sram_din = sram_din + 8'h11;
            end
            if (dv) vid_req = 1'b0;
            if (dc && !hold_cpu) cpu_req = 1'b0;
            if (dl && !hold_ldr) ldr_req = 1'b0;
        end
        chk("acks_seen", seen, nacks);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held while requests toggle
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            vid_req = i[0];
            cpu_req = !i[0];
            ldr_req = i[1];
            cpu_we_n = i[1];
            @(negedge clk);
            chk("rst_acks", {vid_ack, cpu_ack, ldr_ack}, 3'b000);
            chk("rst_we_n", sram_we_n, 1'b1);
            chk("rst_oe", sram_oe, 1'b0);
            chk("rst_grant", grant, 2'b00);
            chk("rst_douts", {vid_dout, cpu_dout, ldr_dout}, 24'h0);
            chk("rst_addr", sram_addr, 19'h0);
            chk("rst_sram_dout", sram_dout, 8'h0);
        end
        @(posedge clk); #1;
        vid_req = 1'b0;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        cpu_we_n = 1'b1;
        rst_n = 1'b1;

        // CPU read
        cpu_access(1'b1, 19'h12345, 8'h00, 8'hA5, 8'hA5);

        // CPU write; other dout registers untouched
        cpu_access(1'b0, 19'h7FFFF, 8'h3C, 8'hFF, 8'hA5);
        chk("wr_vid_dout", vid_dout, 8'h00);
        chk("wr_ldr_dout", ldr_dout, 8'h00);

        // Three simultaneous requests
        @(posedge clk); #1;
        ack_cyc.delete();
        vid_addr = 19'h00010;
        cpu_addr = 19'h00020;
        ldr_addr = 19'h00030;
        cpu_we_n = 1'b1;
        ldr_we_n = 1'b1;
        push(1, 8'h11);
        push(2, 8'h22);
        push(3, 8'h33);
        vid_req = 1'b1;
        cpu_req = 1'b1;
        ldr_req = 1'b1;
        run_acks(3, 40, 8'h11, 1'b0, 1'b0);
        chk("slot_count", ack_cyc.size(), 3);
        if (ack_cyc.size() == 3) begin
            chk("slot_gap1", ack_cyc[1] - ack_cyc[0], AC + 2);
            chk("slot_gap2", ack_cyc[2] - ack_cyc[1], AC + 2);
        end

        // Loader starvation under continuous CPU traffic
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++)
            push((i == 4 || i == 9) ? 3 : 2, 8'h40 + 8'(i * 17));
        cpu_req = 1'b1;
        ldr_req = 1'b1;
        run_acks(10, 120, 8'h40, 1'b1, 1'b1);
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        chk("starve_vid_dout", vid_dout, 8'h11);
        repeat (3) @(posedge clk);
        #1;

        // Reset in phase 1 of a write aborts the access
        cpu_req = 1'b1;
        cpu_we_n = 1'b0;
        cpu_addr = 19'h00100;
        cpu_din = 8'hE7;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("abort_ph0_we_n", sram_we_n, 1'b1);
        chk("abort_ph0_oe", sram_oe, 1'b1);
        @(posedge clk); #1;
        chk("abort_ph1_we_n", sram_we_n, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_we_n", sram_we_n, 1'b1);
        chk("abort_oe", sram_oe, 1'b0);
        chk("abort_grant", grant, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_noack", cpu_ack, 1'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_cpu_dout", cpu_dout, 8'h00);
        chk("abort_ldr_dout", ldr_dout, 8'h00);
        chk("abort_vid_dout", vid_dout, 8'h00);

        // Reissued read after reset has normal latency
        cpu_access(1'b1, 19'h00ABC, 8'h00, 8'h96, 8'h96);

        repeat (3) @(posedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
